fetch_redirect_unit: RTL and testbench
======================================

Name: fetch_redirect_unit

Overview:
- PC-generation and fetch-redirect stage for the 3-stage RISC-V core (IF -> EX -> WB).
- Owns the fetch PC and the PC of the instruction currently in EX.
- Consumes the branch/jump decision (`diverge`) and the ALU-computed target produced in EX.
- Steers fetch, kills the wrong-path instruction and holds a redirect across pipeline stalls.

Parameters:
- RESET_PC, 32'h0000_2000, fetch address loaded on reset.
- TRAP_VEC, 32'h0000_0100, redirect address for a misaligned target (used only with the optional feature).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  global pipeline stall (I$/D$ miss); freezes PC state.
- diverge  in  1  EX-stage take-branch/jump decision.
- is_jalr  in  1  EX instruction is JALR; target bit 0 is cleared.
- target  in  32  EX-stage ALU output (branch/jump target).
- fetch_pc  out  32  address to instruction memory (registered).
- imem_re  out  1  instruction-memory read enable = ~stall.
- ex_pc  out  32  PC of the instruction in EX (registered).
- ex_pc_plus4  out  32  ex_pc + 4, link value for JAL/JALR.
- ex_valid  out  1  instruction in EX is real (0 = bubble/killed).
- redirect  out  1  one-cycle pulse; a redirect was applied this edge.
- redirect_pending  out  1  redirect latched, waiting on stall release.
- misalign_trap  out  1  one-cycle pulse; misaligned target trapped (0 when feature off).

Behaviour:
- Reset (rst=1 at edge):
  - fetch_pc=RESET_PC, ex_pc=0, ex_valid=0, redirect=0, redirect_pending=0, misalign_trap=0.
  - State goes to RUN; rst overrides stall and diverge.
- Effective decision: take = diverge & ex_valid. A killed or bubble instruction never redirects.
- Target alignment: eff_target = is_jalr ? {target[31:1],1'b0} : target. All arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- FSM states: RUN, PEND.
- RUN, stall=0, take=0:
  - ex_pc <= fetch_pc, ex_valid <= 1, fetch_pc <= fetch_pc + 4.
- RUN, stall=0, take=1:
  - fetch_pc <= eff_target, ex_pc <= fetch_pc, ex_valid <= 0 (kills the wrong-path instruction already fetched).
  - redirect pulses 1 for the following cycle.
  - Branch penalty is exactly 1 bubble.
- RUN, stall=1, take=0: all PC/valid regs hold.
- RUN, stall=1, take=1:
  - Latch eff_target into pend_target; PC/valid regs hold; go to PEND.
  - redirect_pending=1 from the next cycle.
- PEND, stall=1:
  - Hold everything. diverge/target inputs are ignored; the latched value wins even if the ALU output changes under forwarding.
- PEND, stall=0:
  - fetch_pc <= pend_target, ex_pc <= fetch_pc, ex_valid <= 0.
  - redirect pulses; redirect_pending clears; go to RUN.
- Back-to-back: a redirect always leaves a bubble in EX, so two consecutive takes are impossible by construction.
- Reset mid-PEND discards the latched target.
- ex_pc_plus4 is combinational from ex_pc.
- No combinational path from diverge/target to fetch_pc.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - If take and eff_target[1:0] != 2'b00, the redirect goes to TRAP_VEC instead of eff_target.
  - misalign_trap pulses together with redirect.
  - Under stall, the check applies to the latched target at latch time, and the trap pulse coincides with the deferred redirect.
- Undefined:
  - Target bits [1:0] are forced to 0 before use; misalign_trap is tied 0.

Test Plan:
- Reset, rst=1 two cycles then 0, no stall -> fetch_pc sequence 0x2000, 0x2004, 0x2008; ex_valid goes 0 then 1 one cycle after release.
- Taken branch: ex_pc=0x2008, diverge=1, target=0x2100 -> next cycle fetch_pc=0x2100, ex_valid=0, redirect=1; following cycle ex_pc=0x2100, ex_valid=1.
- Stalled redirect: diverge=1, target=0x3000 with stall=1 for 3 cycles, target changed to 0x4444 during stall -> redirect_pending=1 for those cycles, fetch_pc frozen; after stall drops, fetch_pc=0x3000, redirect=1.
- JALR: is_jalr=1, target=0x2203 -> fetch_pc=0x2202, which is misaligned:
  - With MISALIGN_TRAP_EN: fetch_pc=0x100, misalign_trap=1.
  - Without it: fetch_pc=0x2200.
- Killed instruction: diverge held 1 on the cycle after a redirect (ex_valid=0) -> no second redirect; fetch_pc increments by 4.
- Wrap and reset mid-PEND: fetch_pc=0xFFFF_FFFC -> next 0x0. Separately, rst asserted while in PEND -> fetch_pc=0x2000, redirect_pending=0.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - PC generation and fetch redirect for the IF/EX/WB core
// Optional feature macro: MISALIGN_TRAP_EN (misaligned redirect targets go to TRAP_VEC)
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        diverge,
  input  logic        is_jalr,
  input  logic [31:0] target,
  output logic [31:0] fetch_pc,
  output logic        imem_re,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_pc_plus4,
  output logic        ex_valid,
  output logic        redirect,
  output logic        redirect_pending,
  output logic        misalign_trap
);

  typedef enum logic {RUN, PEND} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic        ex_valid_q, ex_valid_d;
  logic        redirect_q, redirect_d;
  logic        misalign_trap_q, misalign_trap_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        pend_trap_q, pend_trap_d;

  logic        take;
  logic [31:0] eff_target;
  logic [31:0] redir_target;
  logic        redir_trap;

  // A bubble or killed instruction in EX can never steer fetch
  assign take       = diverge & ex_valid_q;
  assign eff_target = is_jalr ? {target[31:1], 1'b0} : target;

`ifdef MISALIGN_TRAP_EN
  // Misaligned targets are sent to the trap vector and flagged
  always_comb begin
    redir_trap   = (eff_target[1:0] != 2'b00);
    redir_target = redir_trap ? TRAP_VEC : eff_target;
  end
`else
  // Without the trap, low target bits are simply dropped
  always_comb begin
    redir_trap   = 1'b0;
    redir_target = eff_target & 32'hFFFF_FFFC;
  end

  // TRAP_VEC only has a consumer when the trap feature is built in
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
`endif

  // Next-state logic for PC, EX tracking and the deferred-redirect FSM
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    ex_pc_d         = ex_pc_q;
    ex_valid_d      = ex_valid_q;
    redirect_d      = 1'b0;
    misalign_trap_d = 1'b0;
    pend_target_d   = pend_target_q;
    pend_trap_d     = pend_trap_q;
    case (state_q)
      RUN: begin
        if (!stall) begin
          ex_pc_d = fetch_pc_q;
          if (take) begin
            fetch_pc_d      = redir_target;
            ex_valid_d      = 1'b0;
            redirect_d      = 1'b1;
            misalign_trap_d = redir_trap;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            ex_valid_d = 1'b1;
          end
        end else if (take) begin
          // Capture now: the ALU output may change under forwarding while stalled
          pend_target_d = redir_target;
          pend_trap_d   = redir_trap;
          state_d       = PEND;
        end
      end
      PEND: begin
        if (!stall) begin
          fetch_pc_d      = pend_target_q;
          ex_pc_d         = fetch_pc_q;
          ex_valid_d      = 1'b0;
          redirect_d      = 1'b1;
          misalign_trap_d = pend_trap_q;
          state_d         = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State registers with synchronous reset; reset also drops any latched target
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      fetch_pc_q      <= RESET_PC;
      ex_pc_q         <= 32'd0;
      ex_valid_q      <= 1'b0;
      redirect_q      <= 1'b0;
      misalign_trap_q <= 1'b0;
      pend_target_q   <= 32'd0;
      pend_trap_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      ex_pc_q         <= ex_pc_d;
      ex_valid_q      <= ex_valid_d;
      redirect_q      <= redirect_d;
      misalign_trap_q <= misalign_trap_d;
      pend_target_q   <= pend_target_d;
      pend_trap_q     <= pend_trap_d;
    end
  end

  assign fetch_pc         = fetch_pc_q;
  assign imem_re          = ~stall;
  assign ex_pc            = ex_pc_q;
  assign ex_pc_plus4      = ex_pc_q + 32'd4;
  assign ex_valid         = ex_valid_q;
  assign redirect         = redirect_q;
  assign redirect_pending = (state_q == PEND);
  assign misalign_trap    = misalign_trap_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - directed scoreboard bench for fetch_redirect_unit
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        diverge;
  logic        is_jalr;
  logic [31:0] target;
  logic [31:0] fetch_pc;
  logic        imem_re;
  logic [31:0] ex_pc;
  logic [31:0] ex_pc_plus4;
  logic        ex_valid;
  logic        redirect;
  logic        redirect_pending;
  logic        misalign_trap;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MISALIGN_TRAP_EN
  localparam logic [31:0] JALR_FP = 32'h0000_0100;
  localparam logic        JALR_TR = 1'b1;
  localparam logic [31:0] STL_FP  = 32'h0000_0100;
  localparam logic        STL_TR  = 1'b1;
`else
  localparam logic [31:0] JALR_FP = 32'h0000_2200;
  localparam logic        JALR_TR = 1'b0;
  localparam logic [31:0] STL_FP  = 32'h0000_3004;
  localparam logic        STL_TR  = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] fp;
    logic [31:0] ep;
    logic        ev;
    logic        rd;
    logic        pd;
    logic        tr;
    logic        re;
  } exp_t;

  exp_t exp_q[$];

  fetch_redirect_unit dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .diverge          (diverge),
    .is_jalr          (is_jalr),
    .target           (target),
    .fetch_pc         (fetch_pc),
    .imem_re          (imem_re),
    .ex_pc            (ex_pc),
    .ex_pc_plus4      (ex_pc_plus4),
    .ex_valid         (ex_valid),
    .redirect         (redirect),
    .redirect_pending (redirect_pending),
    .misalign_trap    (misalign_trap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, queue the expected post-edge state, then check it
  task automatic step(input logic r, input logic s, input logic d, input logic j,
                      input logic [31:0] t, input string tag,
                      input logic [31:0] fp, input logic [31:0] ep, input logic ev,
                      input logic rd, input logic pd, input logic tr);
    exp_t e;
    exp_t got;
    logic [100:0] obs_v;
    logic [100:0] exp_v;
    rst = r; stall = s; diverge = d; is_jalr = j; target = t;
    e.tag = tag; e.fp = fp; e.ep = ep; e.ev = ev; e.rd = rd; e.pd = pd; e.tr = tr; e.re = ~s;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got   = exp_q.pop_front();
    obs_v = {fetch_pc, ex_pc, ex_pc_plus4, ex_valid, redirect, redirect_pending, misalign_trap, imem_re};
    exp_v = {got.fp, got.ep, got.ep + 32'd4, got.ev, got.rd, got.pd, got.tr, got.re};
    n_tests++;
    assert (obs_v === exp_v) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", got.tag, obs_v, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; diverge = 1'b0; is_jalr = 1'b0; target = 32'd0;
    //   rst  stl  div  jalr target         tag            fetch_pc       ex_pc          ev rd pd tr
    step(1'b1,1'b0,1'b0,1'b0,32'h0,         "reset0",      32'h0000_2000, 32'h0,         0, 0, 0, 0);
    step(1'b1,1'b0,1'b1,1'b0,32'h1234,      "reset1",      32'h0000_2000, 32'h0,         0, 0, 0, 0);
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         "run0",        32'h0000_2004, 32'h0000_2000, 1, 0, 0, 0);
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         "run1",        32'h0000_2008, 32'h0000_2004, 1, 0, 0, 0);
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         "run2",        32'h0000_200C, 32'h0000_2008, 1, 0, 0, 0);
    step(1'b0,1'b0,1'b1,1'b0,32'h0000_2100, "branch",      32'h0000_2100, 32'h0000_200C, 0, 1, 0, 0);
    step(1'b0,1'b0,1'b1,1'b0,32'h0000_2500, "killed",      32'h0000_2104, 32'h0000_2100, 1, 0, 0, 0);
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         "after_br",    32'h0000_2108, 32'h0000_2104, 1, 0, 0, 0);
    step(1'b0,1'b1,1'b1,1'b0,32'h0000_3000, "stall_latch", 32'h0000_2108, 32'h0000_2104, 1, 0, 1, 0);
    step(1'b0,1'b1,1'b1,1'b0,32'h0000_4444, "stall_hold1", 32'h0000_2108, 32'h0000_2104, 1, 0, 1, 0);
    step(1'b0,1'b1,1'b0,1'b0,32'h0000_4444, "stall_hold2", 32'h0000_2108, 32'h0000_2104, 1, 0, 1, 0);
    step(1'b0,1'b0,1'b0,1'b0,32'h0000_4444, "pend_apply",  32'h0000_3000, 32'h0000_2108, 0, 1, 0, 0);
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         "pend_after",  32'h0000_3004, 32'h0000_3000, 1, 0, 0, 0);
    step(1'b0,1'b0,1'b1,1'b1,32'h0000_2203, "jalr",        JALR_FP,       32'h0000_3004, 0, 1, 0, JALR_TR);
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         "jalr_after",  JALR_FP + 4,   JALR_FP,       1, 0, 0, 0);
    step(1'b0,1'b0,1'b1,1'b0,32'hFFFF_FFFC, "to_top",      32'hFFFF_FFFC, JALR_FP + 4,   0, 1, 0, 0);
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         "wrap",        32'h0000_0000, 32'hFFFF_FFFC, 1, 0, 0, 0);
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         "post_wrap",   32'h0000_0004, 32'h0000_0000, 1, 0, 0, 0);
    step(1'b0,1'b1,1'b1,1'b0,32'h0000_5000, "pend_b4rst",  32'h0000_0004, 32'h0000_0000, 1, 0, 1, 0);
    step(1'b1,1'b1,1'b1,1'b0,32'h0000_5000, "rst_in_pend", 32'h0000_2000, 32'h0,         0, 0, 0, 0);
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         "rst_discard", 32'h0000_2004, 32'h0000_2000, 1, 0, 0, 0);
    step(1'b0,1'b1,1'b1,1'b0,32'h0000_3006, "mis_latch",   32'h0000_2004, 32'h0000_2000, 1, 0, 1, 0);
    step(1'b0,1'b1,1'b1,1'b0,32'h0000_3000, "mis_hold",    32'h0000_2004, 32'h0000_2000, 1, 0, 1, 0);
    step(1'b0,1'b0,1'b0,1'b0,32'h0000_3000, "mis_apply",   STL_FP,        32'h0000_2004, 0, 1, 0, STL_TR);
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         "mis_after",   STL_FP + 4,    STL_FP,        1, 0, 0, 0);
    step(1'b0,1'b1,1'b0,1'b0,32'h0,         "stall_notake",STL_FP + 4,    STL_FP,        1, 0, 0, 0);
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         "stall_rel",   STL_FP + 8,    STL_FP + 4,    1, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
